aes_stream_adapter: RTL and testbench

AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

---
 rtl/aes_stream_adapter_if.sv | 21 ++
 rtl/aes_stream_adapter.sv | 98 +++++++++
 tb/tb_aes_stream_adapter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_adapter_if.sv
// Word streams around the AES adapter: 32-bit words in, 32-bit cipher words out.
// The master drives input words and output acceptance; the slave is the adapter.
interface aes_stream_adapter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_stream_adapter.sv
// Loads an optional key and a plaintext block into an external AES core, drains the cipher as 4 words.
// Latency: out_valid rises SETTLE_CYCLES cycles after the last plaintext word is accepted.
// Backpressure: in_ready only in the load phases; a drain word is held until out_ready accepts it.
module aes_stream_adapter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_stream_adapter_if.slave  strm,
    input  logic                 key_reload,
    output logic [127:0]         plain_text,
    output logic [0:127]         key,
    input  logic [127:0]         cipher,
    output logic                 busy
);
    typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, SETTLE, DRAIN} state_t;

    state_t       state;
    logic [1:0]   word_cnt;
    logic [3:0]   settle_cnt;
    logic [127:0] cipher_q;
    logic         out_valid;
    logic         out_last;
    logic [31:0]  out_data;
    logic         in_acc;
    logic         out_acc;

    assign strm.in_ready  = !rst && (state == LOAD_KEY || state == LOAD_PT);
    assign strm.out_valid = out_valid;
    assign strm.out_data  = out_data;
    assign strm.out_last  = out_last;

    assign in_acc  = strm.in_valid && strm.in_ready;
    assign out_acc = out_valid && strm.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_KEY;
            word_cnt   <= 2'd0;
            settle_cnt <= 4'd0;
            plain_text <= '0;
            key        <= '0;
            cipher_q   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                LOAD_KEY: begin
                    if (in_acc) begin
                        // Key bus is ascending: first byte of word n lands at key[32n].
                        key[{word_cnt, 5'd0} +: 32] <= strm.in_data;
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) state <= LOAD_PT;
                    end
                end
                LOAD_PT: begin
                    if (in_acc) begin
                        plain_text[7'd127 - {word_cnt, 5'd0} -: 32] <= strm.in_data;
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            state      <= SETTLE;
                            settle_cnt <= 4'(SETTLE_CYCLES);
                            busy       <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd1) begin
                        cipher_q  <= cipher;
                        out_data  <= cipher[127:96];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= DRAIN;
                    end
                    settle_cnt <= settle_cnt - 4'd1;
                end
                DRAIN: begin
                    if (out_acc) begin
                        // cipher_q shifts so the next word is always at [95:64].
                        cipher_q <= {cipher_q[95:0], 32'h0};
                        out_data <= cipher_q[95:64];
                        out_last <= (word_cnt == 2'd2);
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= key_reload ? LOAD_KEY : LOAD_PT;
                        end
                    end
                end
                default: state <= LOAD_KEY;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter with a behavioural AES-128 core and an output scoreboard.
module tb_aes_stream_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, hold3, key_reload;
    logic [127:0] pt1, pt3, cipher1, cipher3;
    logic [0:127] key1, key3;
    logic         busy1, busy3;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           fc;
    logic [32:0]  sb [$];

    localparam logic [31:0] FK [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    localparam logic [31:0] FP [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    localparam logic [31:0] FC [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

    aes_stream_adapter_if bus();
    aes_stream_adapter_if bus3();

    aes_stream_adapter dut1 (
        .clk(clk), .rst(rst), .strm(bus), .key_reload(key_reload),
        .plain_text(pt1), .key(key1), .cipher(cipher1), .busy(busy1)
    );

    aes_stream_adapter #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst || hold3), .strm(bus3), .key_reload(1'b1),
        .plain_text(pt3), .key(key3), .cipher(cipher3), .busy(busy3)
    );

    assign bus3.in_valid  = bus.in_valid;
    assign bus3.in_data   = bus.in_data;
    assign bus3.out_ready = 1'b1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y, r;
        y = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            y = gmul(y, y);
            r = gmul(r, y);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [16];
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int rn = 1; rn <= 10; rn++) begin
            w[0] = w[0] ^ sbox(w[13]) ^ rc;
            w[1] = w[1] ^ sbox(w[14]);
            w[2] = w[2] ^ sbox(w[15]);
            w[3] = w[3] ^ sbox(w[12]);
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                if (rn < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'd2) ^ gmul(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'd2) ^ gmul(t[4*c+2], 8'd3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'd2) ^ gmul(t[4*c+3], 8'd3);
                    s[4*c+3] = gmul(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'd2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    assign cipher1 = aes_enc(key1, pt1);
    assign cipher3 = aes_enc(key3, pt3);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each accepted output word is checked against the oldest expectation.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("extra_word", bus.out_valid, 1'b0);
            else chk("out_word", {bus.out_last, bus.out_data}, sb.pop_front());
        end
    end

    task automatic send(input logic [31:0] w, input int max_gap);
        int  n;
        bit  acc;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic frame(input bit with_key, input int gap, input int bp, input bit lat, output int cycles);
        int c0, n;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.out_ready = (bp == 0);
        for (int i = 0; i < 4; i++) sb.push_back({(i == 3), FC[i]});
        if (with_key) for (int i = 0; i < 4; i++) send(FK[i], gap);
        for (int i = 0; i < 4; i++) send(FP[i], gap);
        @(negedge clk);
        chk("settle_busy", busy1, 1'b1);
        chk("settle_in_ready", bus.in_ready, 1'b0);
        chk("settle_out_valid", bus.out_valid, 1'b0);
        if (lat) begin
            chk("lat3_busy", busy3, 1'b1);
            chk("lat3_valid_e0", bus3.out_valid, 1'b0);
            repeat (2) begin
                @(negedge clk);
                chk("lat3_valid_early", bus3.out_valid, 1'b0);
            end
            @(negedge clk);
            chk("lat3_valid_rise", bus3.out_valid, 1'b1);
            chk("lat3_first_word", bus3.out_data, FC[0]);
        end
        if (bp > 0) begin
            n = 0;
            while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
            chk("bp_valid_timeout", bus.out_valid, 1'b1);
            repeat (bp) begin
                @(negedge clk);
                chk("bp_hold_data", bus.out_data, FC[0]);
                chk("bp_hold_valid", bus.out_valid, 1'b1);
                chk("bp_hold_last", bus.out_last, 1'b0);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
        end
        wait_drain();
        cycles = cyc - c0;
        @(negedge clk);
        chk("no_extra_valid", bus.out_valid, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_out_data"}, bus.out_data, 32'h0);
        chk({tag, "_out_last"}, bus.out_last, 1'b0);
        chk({tag, "_busy"}, busy1, 1'b0);
        chk({tag, "_plain_text"}, pt1, 128'h0);
        chk({tag, "_key"}, key1, 128'h0);
    endtask

    initial begin
        rst = 1'b1;
        hold3 = 1'b0;
        key_reload = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1'b1);

        // FIPS-197 frame with key; also checks the SETTLE_CYCLES=3 instance.
        frame(1'b1, 0, 0, 1'b1, fc);
        chk("frame_cycles_key", fc, 13);
        chk("fips_key", key1, 128'h000102030405060708090a0b0c0d0e0f);
        chk("fips_pt", pt1, 128'h00112233445566778899aabbccddeeff);
        hold3 = 1'b1;

        // Key reuse: the FSM waits in LOAD_PT, only plaintext is sent.
        chk("reuse_in_ready", bus.in_ready, 1'b1);
        key_reload = 1'b1;
        frame(1'b0, 0, 0, 1'b0, fc);
        chk("frame_cycles_pt", fc, 9);
        chk("reuse_key_held", key1, 128'h000102030405060708090a0b0c0d0e0f);

        frame(1'b1, 0, 5, 1'b0, fc);
        frame(1'b1, 3, 0, 1'b0, fc);

        // Reset after six accepted words.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(FK[i], 0);
        for (int i = 0; i < 2; i++) send(FP[i], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midload_rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midload");
        chk("midload_in_ready", bus.in_ready, 1'b1);
        frame(1'b1, 0, 0, 1'b0, fc);

        // Reset while drain word 2 is presented.
        @(posedge clk);
        #1;
        sb.push_back({1'b0, FC[0]});
        sb.push_back({1'b0, FC[1]});
        for (int i = 0; i < 4; i++) send(FK[i], 0);
        for (int i = 0; i < 4; i++) send(FP[i], 0);
        wait_drain();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("drain_word2", bus.out_data, FC[2]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk_zero("drain_rst");
        chk("drain_rst_in_ready", bus.in_ready, 1'b1);
        frame(1'b1, 0, 0, 1'b0, fc);
        chk("post_rst_frame_cycles", fc, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
